pixel_sequencer: RTL and testbench

Sequences the per-pixel ALU. It holds a loadable instruction program and issues one instruction per cycle for the current pixel. It steps the x/y/frame coordinates the ALU reads, and hands each finished 12-bit pixel to the downstream sink over a valid/ready handshake. It sits between the host program-load path and the pixel ALU/output FIFO.

---
 rtl/pixel_pkg.sv | 71 +++++++
 rtl/pixel_prog_ram.sv | 29 ++
 rtl/pixel_sequencer.sv | 158 +++++++++++++++
 tb/tb_pixel_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel sequencer: instruction layout, opcodes,
// ALU register indices, the NOP word and the sequencer state encoding.
package pixel_pkg;

  localparam int INSTR_W = 46;
  localparam int COORD_W = 32;
  localparam int PIXEL_W = 12;

  // Instruction field positions
  localparam int DEST_MSB      = 45;
  localparam int DEST_LSB      = 43;
  localparam int SRCA_MSB      = 42;
  localparam int SRCA_LSB      = 40;
  localparam int SRCB_MSB      = 39;
  localparam int SRCB_LSB      = 37;
  localparam int OP_MSB        = 36;
  localparam int OP_LSB        = 33;
  localparam int USE_CONST_BIT = 32;
  localparam int CONST_MSB     = 31;
  localparam int CONST_LSB     = 0;

  typedef enum logic [3:0] {
    OP_MOV   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MUL   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_SHL   = 4'h7,
    OP_SHR   = 4'h8,
    OP_MIN   = 4'h9,
    OP_MAX   = 4'hA,
    OP_CMPLT = 4'hB
  } opcode_e;

  localparam logic [2:0] REG_X      = 3'd4;
  localparam logic [2:0] REG_Y      = 3'd5;
  localparam logic [2:0] REG_F      = 3'd6;
  localparam logic [2:0] REG_RESULT = 3'd7;

  typedef struct packed {
    logic [2:0]  dest;
    logic [2:0]  srca;
    logic [2:0]  srcb;
    opcode_e     op;
    logic        use_const;
    logic [31:0] cnst;
  } instr_t;

  // Writing the read-only X register makes this a no-op for the ALU.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 46'h2000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXEC      = 2'd1,
    ST_EMIT      = 2'd2,
    ST_WAIT_SYNC = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] f;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } coord_t;

  function automatic logic [INSTR_W-1:0] pack_instr(input instr_t i);
    return i;
  endfunction

endpackage

// File: rtl/pixel_prog_ram.sv
// Instruction store: DEPTH x INSTR_W words, synchronous write, asynchronous
// read so the addressed instruction is available in the same cycle as pc.
module pixel_prog_ram
  import pixel_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  // NOTE: the storage array has no reset; only the sequencer control state
  // is cleared, and the host reloads the program as needed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pixel_sequencer.sv
// Per-pixel ALU sequencer: issues the loaded program once per pixel, steps
// x/y/frame coordinates and hands results to the sink over valid/ready.
// Optional feature macro: PIXEL_SEQ_FRAME_SYNC_EN (adds frame_start/WAIT_SYNC).
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter  int PROG_DEPTH = 64,
  parameter  int WIDTH      = 640,
  parameter  int HEIGHT     = 480,
  localparam int AW         = $clog2(PROG_DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_we,
  input  logic [AW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [AW-1:0]      prog_last,
  input  logic               run,
`ifdef PIXEL_SEQ_FRAME_SYNC_EN
  input  logic               frame_start,
`endif
  output logic [INSTR_W-1:0] instruction,
  output logic [COORD_W-1:0] x_coord,
  output logic [COORD_W-1:0] y_coord,
  output logic [COORD_W-1:0] f_number,
  input  logic [PIXEL_W-1:0] alu_value,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               frame_done,
  output logic               busy
);

  seq_state_e         state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [AW-1:0]      last_q, last_d;
  coord_t             coord_q, coord_d;
  logic [INSTR_W-1:0] store_rdata;
  logic               store_we;
  logic               line_end;
  logic               frame_end;

  // The store is frozen while a program is in flight.
  assign store_we = prog_we && (state_q == ST_IDLE);

  pixel_prog_ram #(
    .DEPTH (PROG_DEPTH)
  ) u_prog_ram (
    .clk     (clk),
    .we_i    (store_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (store_rdata)
  );

  assign line_end  = (coord_q.x == COORD_W'(WIDTH - 1));
  assign frame_end = line_end && (coord_q.y == COORD_W'(HEIGHT - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed by the comb processes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      last_q  <= '0;
      coord_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      last_q  <= last_d;
      coord_q <= coord_d;
    end
  end

  // NOTE: every comb output starts from a default so no path infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    last_d  = last_q;
    coord_d = coord_q;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_EXEC;
          pc_d    = '0;
          last_d  = prog_last;
        end
      end

      ST_EXEC: begin
        if (pc_q == last_q) begin
          state_d = ST_EMIT;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end

      ST_EMIT: begin
        if (pixel_ready) begin
          pc_d      = '0;
          coord_d.x = line_end ? '0 : coord_q.x + 32'd1;
          if (line_end) begin
            coord_d.y = frame_end ? '0 : coord_q.y + 32'd1;
          end
          if (frame_end) begin
            coord_d.f = coord_q.f + 32'd1;
          end
          state_d = run ? ST_EXEC : ST_IDLE;
`ifdef PIXEL_SEQ_FRAME_SYNC_EN
          if (frame_end && run) begin
            state_d = ST_WAIT_SYNC;
          end
`endif
        end
      end

      ST_WAIT_SYNC: begin
`ifdef PIXEL_SEQ_FRAME_SYNC_EN
        if (!run) begin
          state_d = ST_IDLE;
        end else if (frame_start) begin
          state_d = ST_EXEC;
          pc_d    = '0;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    instruction = NOP_INSTR;
    pixel_valid = 1'b0;
    frame_done  = 1'b0;
    busy        = (state_q != ST_IDLE);

    unique case (state_q)
      ST_EXEC: instruction = store_rdata;
      ST_EMIT: begin
        pixel_valid = 1'b1;
        frame_done  = pixel_ready && frame_end;
      end
      default: ;
    endcase
  end

  // The ALU holds its result during EMIT because only NOPs are issued there.
  assign pixel_data = alu_value;
  assign x_coord    = coord_q.x;
  assign y_coord    = coord_q.y;
  assign f_number   = coord_q.f;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer with a small registered ALU model
// (MOV of X/Y/F or a constant into r7).
`timescale 1ns/1ps
module tb_pixel_sequencer;

  localparam int PD = 16;
  localparam int AW = 4;
  localparam int W  = 4;
  localparam int H  = 2;

  localparam logic [45:0] NOP   = 46'h2000_0000_0000;
  localparam logic [45:0] MOV_X = {3'd7, 3'd4, 3'd0, 4'd0, 1'b0, 32'd0};
  localparam logic [45:0] MOV_Y = {3'd7, 3'd5, 3'd0, 4'd0, 1'b0, 32'd0};
  localparam logic [45:0] MOV_K = {3'd7, 3'd0, 3'd0, 4'd0, 1'b1, 32'h0000_0ABC};

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [45:0]   prog_data;
  logic [AW-1:0] prog_last;
  logic          run;
  logic          frame_start;
  logic [45:0]   instruction;
  logic [31:0]   x_coord, y_coord, f_number;
  logic [11:0]   alu_value;
  logic          pixel_valid;
  logic          pixel_ready;
  logic [11:0]   pixel_data;
  logic          frame_done;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_sequencer #(
    .PROG_DEPTH (PD),
    .WIDTH      (W),
    .HEIGHT     (H)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_last   (prog_last),
    .run         (run),
`ifdef PIXEL_SEQ_FRAME_SYNC_EN
    .frame_start (frame_start),
`endif
    .instruction (instruction),
    .x_coord     (x_coord),
    .y_coord     (y_coord),
    .f_number    (f_number),
    .alu_value   (alu_value),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .pixel_data  (pixel_data),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  // Registered ALU model: retires one instruction per clock.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_value <= '0;
    end else if (instruction[45:43] == 3'd7) begin
      if (instruction[32]) alu_value <= instruction[11:0];
      else begin
        case (instruction[42:40])
          3'd4:    alu_value <= x_coord[11:0];
          3'd5:    alu_value <= y_coord[11:0];
          3'd6:    alu_value <= f_number[11:0];
          default: alu_value <= '0;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [45:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic wait_valid(input int budget, input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!pixel_valid && n < budget);
    if (!pixel_valid) begin
      total++;
      bad++;
      $display("FAIL %s: pixel_valid not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", pixel_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL rst_instr: got %h want %h", instruction, NOP); end
    total++; if ({x_coord, y_coord, f_number} !== 96'd0) begin bad++; $display("FAIL rst_coords: got x=%0d y=%0d f=%0d want 0", x_coord, y_coord, f_number); end
    reset = 1'b0;
    tick();
  endtask

  // Two-instruction program: one pixel every 3 cycles, data = y, x steps.
  task automatic test_two_instr();
    int n;
    load(4'd0, MOV_X);
    load(4'd1, MOV_Y);
    prog_last   = 4'd1;
    pixel_ready = 1'b1;
    run         = 1'b1;
    wait_valid(20, "two_first", n);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        wait_valid(20, "two_next", n);
        total++; if (n !== 3) begin bad++; $display("FAIL two_gap: got %0d want 3", n); end
      end
      total++; if (x_coord !== 32'(i)) begin bad++; $display("FAIL two_x: got %0d want %0d", x_coord, i); end
      total++; if (pixel_data !== 12'd0) begin bad++; $display("FAIL two_data: got %h want 0", pixel_data); end
    end
  endtask

  // One-instruction program over a 4x2 frame: frame_done on 8th acceptance.
  task automatic test_frame();
    int k   = 0;
    int cyc = 0;
    reset = 1'b1;
    run   = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    load(4'd0, MOV_X);
    prog_last   = 4'd0;
    pixel_ready = 1'b1;
    run         = 1'b1;
    while (k < 8 && cyc < 60) begin
      tick();
      cyc++;
      if (pixel_valid) begin
        total++; if (pixel_data !== 12'(k % W)) begin bad++; $display("FAIL frame_data: got %0d want %0d", pixel_data, k % W); end
        total++; if (y_coord !== 32'(k / W)) begin bad++; $display("FAIL frame_y: got %0d want %0d", y_coord, k / W); end
        k++;
        total++; if (frame_done !== (k == 8)) begin bad++; $display("FAIL frame_done_acc%0d: got %b want %b", k, frame_done, k == 8); end
      end else begin
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_idle: got %b want 0", frame_done); end
      end
    end
    if (k < 8) begin
      total++; bad++;
      $display("FAIL frame_timeout: got %0d acceptances want 8", k);
    end
    tick();
    total++; if (f_number !== 32'd1) begin bad++; $display("FAIL frame_f: got %0d want 1", f_number); end
    total++; if (x_coord !== 32'd0 || y_coord !== 32'd0) begin bad++; $display("FAIL frame_xy: got x=%0d y=%0d want 0,0", x_coord, y_coord); end
  endtask

  // Sink stalls 5 cycles in EMIT; everything holds until acceptance.
  task automatic test_stall();
    int n;
    logic [11:0] d;
    pixel_ready = 1'b0;
    wait_valid(10, "stall_first", n);
    d = pixel_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (pixel_valid !== 1'b1) begin bad++; $display("FAIL stall_valid: got %b want 1", pixel_valid); end
      total++; if (instruction !== NOP) begin bad++; $display("FAIL stall_instr: got %h want %h", instruction, NOP); end
      total++; if (pixel_data !== d) begin bad++; $display("FAIL stall_data: got %h want %h", pixel_data, d); end
      total++; if (x_coord !== 32'd0) begin bad++; $display("FAIL stall_x: got %0d want 0", x_coord); end
    end
    pixel_ready = 1'b1;
    tick();
    total++; if (x_coord !== 32'd1) begin bad++; $display("FAIL stall_accept_x: got %0d want 1", x_coord); end
    total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL stall_accept_valid: got %b want 0", pixel_valid); end
  endtask

  // Store write attempted during EXEC must be dropped.
  task automatic test_prog_we_exec();
    int n;
    total++; if (instruction !== MOV_X) begin bad++; $display("FAIL we_exec_instr: got %h want %h", instruction, MOV_X); end
    prog_addr = 4'd0;
    prog_data = MOV_K;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) wait_valid(10, "we_next", n);
      total++; if (pixel_data !== 12'((1 + i) % W)) begin bad++; $display("FAIL we_data: got %h want %h", pixel_data, 12'((1 + i) % W)); end
    end
  endtask

  // Reset while pc=1 of a two-instruction program.
  task automatic test_reset_mid_exec();
    int n   = 0;
    int cyc = 0;
    run = 1'b0;
    while (busy && cyc < 20) begin tick(); cyc++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_idle: got busy=%b want 0", busy); end
    load(4'd1, MOV_Y);
    prog_last = 4'd1;
    run       = 1'b1;
    cyc = 0;
    while (instruction !== MOV_Y && cyc < 20) begin tick(); cyc++; end
    total++; if (instruction !== MOV_Y) begin bad++; $display("FAIL mid_pc1: got %h want %h", instruction, MOV_Y); end
    #2 reset = 1'b1;
    #1;
    total++; if (instruction !== NOP) begin bad++; $display("FAIL mid_rst_instr: got %h want %h", instruction, NOP); end
    total++; if (busy !== 1'b0 || pixel_valid !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got busy=%b valid=%b fd=%b want 0", busy, pixel_valid, frame_done); end
    total++; if ({x_coord, y_coord, f_number} !== 96'd0) begin bad++; $display("FAIL mid_rst_coords: got x=%0d y=%0d f=%0d want 0", x_coord, y_coord, f_number); end
    tick();
    reset = 1'b0;
    wait_valid(20, "mid_restart", n);
    total++; if (n !== 3) begin bad++; $display("FAIL mid_restart_lat: got %0d want 3", n); end
    total++; if ({x_coord, y_coord, f_number} !== 96'd0) begin bad++; $display("FAIL mid_restart_coords: got x=%0d y=%0d f=%0d want 0", x_coord, y_coord, f_number); end
    total++; if (pixel_data !== 12'd0) begin bad++; $display("FAIL mid_restart_data: got %h want 0", pixel_data); end
  endtask

`ifdef PIXEL_SEQ_FRAME_SYNC_EN
  task automatic test_frame_sync();
    int cyc = 0;
    reset       = 1'b1;
    run         = 1'b0;
    frame_start = 1'b0;
    tick();
    reset       = 1'b0;
    prog_last   = 4'd0;
    pixel_ready = 1'b1;
    run         = 1'b1;
    while (!frame_done && cyc < 60) begin tick(); cyc++; end
    total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL sync_frame_done: got %b want 1", frame_done); end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (instruction !== NOP || pixel_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL sync_wait: got instr=%h valid=%b busy=%b want NOP,0,1", instruction, pixel_valid, busy); end
    end
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    total++; if (instruction !== MOV_X) begin bad++; $display("FAIL sync_exec: got %h want %h", instruction, MOV_X); end
    tick();
    total++; if (pixel_valid !== 1'b1 || f_number !== 32'd1 || x_coord !== 32'd0) begin bad++; $display("FAIL sync_pixel: got valid=%b f=%0d x=%0d want 1,1,0", pixel_valid, f_number, x_coord); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    prog_we     = 1'b0;
    prog_addr   = '0;
    prog_data   = '0;
    prog_last   = '0;
    run         = 1'b0;
    frame_start = 1'b0;
    pixel_ready = 1'b0;
    test_reset();
    test_two_instr();
    test_frame();
    test_stall();
    test_prog_we_exec();
    test_reset_mid_exec();
`ifdef PIXEL_SEQ_FRAME_SYNC_EN
    test_frame_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
